cpu_clk_gen: RTL and testbench

Parametrised clock-enable and reset sequencer that sits between the board's 50 MHz oscillator and the CPU core. It replaces hand-built divided clocks with NUM_CH independently divisible clock-enable channels, and adds a stretched reset output. It supports run, single-step (debounced push-button) and halt modes, so the CPU can be clocked at full rate, stepped one instruction at a time, or frozen for debug.

---
 rtl/cpu_clk_gen.sv | 143 ++++++++++++++
 tb/tb_cpu_clk_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_gen.sv
// cpu_clk_gen: clock-enable and reset sequencer for the CPU core.
// Generates NUM_CH divided clock-enable pulses with companion 50%-duty
// tick clocks, a stretched reset, and run / single-step / halt control
// driven by a debounced push-button.
//
// Ports:
//   clk       board clock, single domain
//   rst       synchronous active-high reset
//   mode      00 run, 01 step, 10/11 halt
//   div       packed per-channel divisors, channel i at [i*DIV_W +: DIV_W]
//   step_btn  raw asynchronous push-button, active-high
//   ce        one-cycle clock-enable pulse per channel
//   tick_clk  per-channel derived clock, toggles after each ce pulse
//   rst_out   stretched reset for downstream logic
//   step_cnt  accepted single steps, wraps modulo 2^16
module cpu_clk_gen #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic                    step_btn,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       tick_clk,
  output logic                    rst_out,
  output logic [15:0]             step_cnt
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned STEP_W = 16;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;

  logic [HOLD_W-1:0]             hold_cnt;
  logic [1:0]                    sync_q;
  logic [DEB_W-1:0]              deb_cnt;
  logic                          deb_state;
  logic                          deb_q;
  logic [1:0]                    mode_q;
  logic [NUM_CH-1:0][DIV_W-1:0]  cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]  dlat;

  logic mode_chg_c;
  logic deb_rise_c;

  assign mode_chg_c = (mode != mode_q);
  assign deb_rise_c = deb_state & ~deb_q;

  // Reset stretch: rst_out stays high until RST_HOLD edges after rst falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      rst_out  <= 1'b1;
    end else begin
      rst_out <= (hold_cnt < HOLD_W'(RST_HOLD));
      if (hold_cnt < HOLD_W'(RST_HOLD)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Two-flop synchroniser; keeps running during the reset stretch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
    end
  end

  // Debounce: level must differ from the accepted state for DEB_CYCLES
  // consecutive edges; any return to the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst || rst_out) begin
      deb_cnt   <= '0;
      deb_state <= 1'b0;
      deb_q     <= 1'b0;
    end else begin
      deb_q <= deb_state;
      if (sync_q[1] == deb_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_state <= sync_q[1];
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Previous mode, used to detect any mode change.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode;
    end
  end

  // Channel counters, ce generation, tick clocks and step counter.
  // A mode change takes priority over a coincident wrap or step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dlat     <= '0;
      ce       <= '0;
      tick_clk <= '0;
      step_cnt <= '0;
    end else begin
      tick_clk <= tick_clk ^ ce;
      ce       <= '0;
      if (rst_out || mode_chg_c) begin
        cnt  <= '0;
        dlat <= div;
      end else if (mode == MODE_RUN) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (cnt[i] == dlat[i]) begin
            cnt[i]  <= '0;
            dlat[i] <= div[i*DIV_W +: DIV_W];
            ce[i]   <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + DIV_W'(1);
          end
        end
      end else if (mode == MODE_STEP) begin
        cnt  <= '0;
        dlat <= div;
        if (deb_rise_c) begin
          ce       <= '1;
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
      // Halt: counters frozen, no ce.
    end
  end

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Testbench for cpu_clk_gen: table-driven run/halt segments plus
// hand-written step, bounce and mid-step reset sequences, checked by a
// scoreboard queue of per-cycle expectations.
module tb_cpu_clk_gen;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned RST_HOLD   = 16;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int          STEP_LAT   = 2 + int'(DEB_CYCLES);

  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_STEP = 2'b01;
  localparam logic [1:0] M_HALT = 2'b10;

  logic                    clk;
  logic                    rst;
  logic [1:0]              mode;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    step_btn;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       tick_clk;
  logic                    rst_out;
  logic [15:0]             step_cnt;

  cpu_clk_gen #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .RST_HOLD  (RST_HOLD),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .div     (div),
    .step_btn(step_btn),
    .ce      (ce),
    .tick_clk(tick_clk),
    .rst_out (rst_out),
    .step_cnt(step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  ce;
    logic        rst_out;
    logic [1:0]  tick;
    logic [15:0] step;
  } exp_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic [1:0] mode;
    logic [15:0] d1;
    logic [15:0] d0;
    int         reps;
    logic       erst;
    int         f0;
    int         p0;
    int         f1;
    int         p1;
  } vec_t;

  exp_t        sb[$];
  exp_t        chk;
  int          n_cmp;
  int          n_bad;
  logic [1:0]  exp_tick;
  logic [1:0]  prev_ce;
  logic [15:0] exp_step;

  // Channel expected to pulse at segment cycle j: first at f, then every p
  // (p == 0: single pulse at f; f < 0: never).
  function automatic logic hit(input int j, input int f, input int p);
    if (f < 0 || j < f) return 1'b0;
    if (p == 0) return (j == f);
    return ((j - f) % p) == 0;
  endfunction

  function automatic vec_t mkv(input string tag, input logic r, input logic [1:0] m,
                               input logic [15:0] d1, input logic [15:0] d0, input int reps,
                               input logic erst, input int f0, input int p0,
                               input int f1, input int p1);
    vec_t v;
    v.tag = tag; v.rst = r; v.mode = m; v.d1 = d1; v.d0 = d0; v.reps = reps;
    v.erst = erst; v.f0 = f0; v.p0 = p0; v.f1 = f1; v.p1 = p1;
    return v;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic cyc(input logic r, input logic [1:0] m, input logic [31:0] d, input logic b,
                     input logic [1:0] ece, input logic erst, input string tag);
    exp_t e;
    rst = r; mode = m; div = d; step_btn = b;
    if (r) begin
      exp_tick = 2'b00;
      exp_step = 16'd0;
    end else begin
      exp_tick = exp_tick ^ prev_ce;
      if (m == M_STEP && ece != 2'b00) exp_step = exp_step + 16'd1;
    end
    prev_ce   = ece;
    e.tag     = tag;
    e.ce      = ece;
    e.rst_out = erst;
    e.tick    = exp_tick;
    e.step    = exp_step;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Hold the button at b for n cycles; all-channel ce expected at cycle ce_at.
  task automatic hold_btn(input logic [1:0] m, input logic b, input int n, input int ce_at,
                          input string tag);
    for (int s = 0; s < n; s++) begin
      cyc(1'b0, m, {16'd5, 16'd0}, b, (s == ce_at) ? 2'b11 : 2'b00, 1'b0, tag);
    end
  endtask

  // Scoreboard checker: one expectation popped per edge, sampled 1 unit after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      chk = sb.pop_front();
      n_cmp++;
      if (ce !== chk.ce) begin
        n_bad++;
        $display("FAIL %s ce @%0t: got %b want %b", chk.tag, $time, ce, chk.ce);
      end
      n_cmp++;
      if (rst_out !== chk.rst_out) begin
        n_bad++;
        $display("FAIL %s rst_out @%0t: got %b want %b", chk.tag, $time, rst_out, chk.rst_out);
      end
      n_cmp++;
      if (tick_clk !== chk.tick) begin
        n_bad++;
        $display("FAIL %s tick_clk @%0t: got %b want %b", chk.tag, $time, tick_clk, chk.tick);
      end
      n_cmp++;
      if (step_cnt !== chk.step) begin
        n_bad++;
        $display("FAIL %s step_cnt @%0t: got %0d want %0d", chk.tag, $time, step_cnt, chk.step);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  vec_t vt[7];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_tick = 2'b00;
    prev_ce  = 2'b00;
    exp_step = 16'd0;
    rst      = 1'b1;
    mode     = M_RUN;
    div      = '0;
    step_btn = 1'b0;

    // Run-mode segments: {div1, div0}, cycles, expected rst_out, ce schedule.
    vt[0] = mkv("reset",   1'b1, M_RUN,  16'd3, 16'd0, 3,             1'b1, -1, 0, -1, 0);
    vt[1] = mkv("stretch", 1'b0, M_RUN,  16'd3, 16'd0, int'(RST_HOLD), 1'b1, -1, 0, -1, 0);
    vt[2] = mkv("run_3_0", 1'b0, M_RUN,  16'd3, 16'd0, 10,            1'b0,  1, 1,  4, 4);
    vt[3] = mkv("divchg",  1'b0, M_RUN,  16'd1, 16'd0, 10,            1'b0,  0, 1,  2, 2);
    vt[4] = mkv("div5",    1'b0, M_RUN,  16'd5, 16'd0, 4,             1'b0,  0, 1,  0, 6);
    vt[5] = mkv("halt",    1'b0, M_HALT, 16'd5, 16'd0, 6,             1'b0, -1, 0, -1, 0);
    vt[6] = mkv("resume",  1'b0, M_RUN,  16'd5, 16'd0, 13,            1'b0,  1, 1,  6, 6);

    for (int r = 0; r < 7; r++) begin
      for (int j = 0; j < vt[r].reps; j++) begin
        cyc(vt[r].rst, vt[r].mode, {vt[r].d1, vt[r].d0}, 1'b0,
            {hit(j, vt[r].f1, vt[r].p1), hit(j, vt[r].f0, vt[r].p0)},
            vt[r].erst, vt[r].tag);
      end
    end

    // Step mode with a bouncing press, then a clean second press.
    hold_btn(M_STEP, 1'b0, 2, -1, "step_idle");
    cyc(1'b0, M_STEP, {16'd5, 16'd0}, 1'b1, 2'b00, 1'b0, "bounce_hi");
    cyc(1'b0, M_STEP, {16'd5, 16'd0}, 1'b0, 2'b00, 1'b0, "bounce_lo");
    hold_btn(M_STEP, 1'b1, 21, STEP_LAT, "step_hold");
    hold_btn(M_STEP, 1'b0, 12, -1, "step_rel1");
    hold_btn(M_STEP, 1'b1, 12, STEP_LAT, "step_press2");
    hold_btn(M_STEP, 1'b0, 12, -1, "step_rel2");

    // Halt discards button presses.
    hold_btn(M_HALT, 1'b0, 1, -1, "halt_enter");
    hold_btn(M_HALT, 1'b1, 12, -1, "halt_press");
    hold_btn(M_HALT, 1'b0, 12, -1, "halt_rel");

    // Reset in the middle of a press debounce aborts the step.
    hold_btn(M_STEP, 1'b0, 2, -1, "mid_idle");
    hold_btn(M_STEP, 1'b1, 4, -1, "mid_press");
    cyc(1'b1, M_STEP, {16'd5, 16'd0}, 1'b0, 2'b00, 1'b1, "mid_rst");
    cyc(1'b1, M_STEP, {16'd5, 16'd0}, 1'b0, 2'b00, 1'b1, "mid_rst");
    for (int s = 0; s < int'(RST_HOLD); s++) begin
      cyc(1'b0, M_STEP, {16'd5, 16'd0}, 1'b0, 2'b00, 1'b1, "mid_stretch");
    end
    hold_btn(M_STEP, 1'b0, 3, -1, "mid_after");
    hold_btn(M_STEP, 1'b1, 10, STEP_LAT, "post_rst_step");
    hold_btn(M_STEP, 1'b0, 8, -1, "post_rst_rel");

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
